// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: instruction ids,
// FSM state encoding and small decode helpers.
package muldiv_sequencer_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [5:0] INSTR_ADD    = 6'd0;
  localparam logic [5:0] INSTR_MUL    = 6'd32;
  localparam logic [5:0] INSTR_MULH   = 6'd33;
  localparam logic [5:0] INSTR_MULHSU = 6'd34;
  localparam logic [5:0] INSTR_MULHU  = 6'd35;
  localparam logic [5:0] INSTR_DIV    = 6'd36;
  localparam logic [5:0] INSTR_DIVU   = 6'd37;
  localparam logic [5:0] INSTR_REM    = 6'd38;
  localparam logic [5:0] INSTR_REMU   = 6'd39;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  // M ids occupy 32..39, so bit 2 separates div/rem from mul and bit 1 picks rem.
  function automatic logic is_muldiv(input logic [5:0] id);
    return id[5:3] == 3'b100;
  endfunction

  function automatic logic is_div_op(input logic [5:0] id);
    return id[2];
  endfunction

  function automatic logic is_rem_op(input logic [5:0] id);
    return id[2] & id[1];
  endfunction

  function automatic logic signed_a(input logic [5:0] id);
    return (id == INSTR_MUL) || (id == INSTR_MULH) || (id == INSTR_MULHSU) ||
           (id == INSTR_DIV) || (id == INSTR_REM);
  endfunction

  function automatic logic signed_b(input logic [5:0] id);
    return (id == INSTR_MUL) || (id == INSTR_MULH) ||
           (id == INSTR_DIV) || (id == INSTR_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic [5:0]      instr_id;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_addr_in;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;

    modport master (
        output start, instr_id, rs1, rs2, rd_addr_in, flush,
        input  busy, stall, result_valid, result, rd_addr_out
    );

    modport slave (
        input  start, instr_id, rs1, rs2, rd_addr_in, flush,
        output busy, stall, result_valid, result, rd_addr_out
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Multiply: acc = {hi, lo} product, opa = multiplicand, opb = multiplier (shifts right).
// Divide:   acc[XLEN:0] = partial remainder, opa = dividend -> quotient, opb = divisor.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0]   opa_nxt,
    output logic [XLEN-1:0]   opb_nxt
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        acc_nxt = acc;
        opa_nxt = opa;
        opb_nxt = opb;
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (opb[0] ? opa : {XLEN{1'b0}})};
        shifted = {acc[XLEN-1:0], opa[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        if (!is_div) begin
            // Add into the high half, then shift the whole product right by one.
            acc_nxt = {sum, acc[XLEN-1:1]};
            opb_nxt = opb >> 1;
        end else if (!diff[XLEN+1]) begin
            acc_nxt = {{(XLEN-1){1'b0}}, diff[XLEN:0]};
            opa_nxt = {opa[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {{(XLEN-1){1'b0}}, shifted};
            opa_nxt = {opa[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: XLEN-cycle shift-add multiply / restoring divide,
// with divide-by-zero and signed-overflow results returned after one cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2*XLEN-1:0] acc, acc_n, acc_s;
    logic [XLEN-1:0]   opa, opa_n, opa_s;
    logic [XLEN-1:0]   opb, opb_n, opb_s;
    logic [5:0]        op, op_n;
    logic              sa, sa_n, sb, sb_n;
    logic [4:0]        rd_q, rd_n;
    logic [XLEN-1:0]   res_q, res_n, fin;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div_op(op)),
        .acc    (acc),
        .opa    (opa),
        .opb    (opb),
        .acc_nxt(acc_s),
        .opa_nxt(opa_s),
        .opb_nxt(opb_s)
    );

    // Sign fix-up on the last step's outputs; unsigned ops carry sa=sb=0.
    always_comb begin
        prod_s = (sa ^ sb) ? -acc_s : acc_s;
        quo_s  = (sa ^ sb) ? -opa_s : opa_s;
        rem_s  = sa ? -acc_s[XLEN-1:0] : acc_s[XLEN-1:0];
        case (op)
            INSTR_MUL:                            fin = prod_s[XLEN-1:0];
            INSTR_MULH, INSTR_MULHSU, INSTR_MULHU: fin = prod_s[2*XLEN-1:XLEN];
            INSTR_DIV, INSTR_DIVU:                fin = quo_s;
            default:                              fin = rem_s;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        opa_n   = opa;
        opb_n   = opb;
        op_n    = op;
        sa_n    = sa;
        sb_n    = sb;
        rd_n    = rd_q;
        res_n   = res_q;
        case (state)
            S_IDLE: begin
                if (bus.start && is_muldiv(bus.instr_id) && !bus.flush) begin
                    op_n  = bus.instr_id;
                    rd_n  = bus.rd_addr_in;
                    sa_n  = signed_a(bus.instr_id) & bus.rs1[XLEN-1];
                    sb_n  = signed_b(bus.instr_id) & bus.rs2[XLEN-1];
                    opa_n = sa_n ? -bus.rs1 : bus.rs1;
                    opb_n = sb_n ? -bus.rs2 : bus.rs2;
                    cnt_n = '0;
                    acc_n = '0;
                    if (is_div_op(bus.instr_id) && bus.rs2 == '0) begin
                        res_n   = is_rem_op(bus.instr_id) ? bus.rs1 : {XLEN{1'b1}};
                        state_n = S_DONE;
                    end else if (is_div_op(bus.instr_id) && signed_a(bus.instr_id) &&
                                 bus.rs1 == INT_MIN && bus.rs2 == {XLEN{1'b1}}) begin
                        res_n   = is_rem_op(bus.instr_id) ? '0 : INT_MIN;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    state_n = S_IDLE;
                end else begin
                    acc_n = acc_s;
                    opa_n = opa_s;
                    opb_n = opb_s;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        res_n   = fin;
                        state_n = S_DONE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            op    <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            opa   <= opa_n;
            opb   <= opb_n;
            op    <= op_n;
            sa    <= sa_n;
            sb    <= sb_n;
            rd_q  <= rd_n;
            res_q <= res_n;
        end
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.stall        = (bus.start && is_muldiv(bus.instr_id) && state == S_IDLE) ||
                              (state == S_BUSY);
    // A flush arriving in DONE suppresses the pulse the pipeline would otherwise see.
    assign bus.result_valid = (state == S_DONE) && !bus.flush;
    assign bus.result       = res_q;
    assign bus.rd_addr_out  = rd_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int LIMIT = 100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Issues one op at posedge+1, returns the result and first-valid latency
    // (1 = valid right after the accepting edge). Leaves the bench at posedge+1.
    task automatic run_op(input logic [5:0] id, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output bit stall_ok, output bit pulse_ok, output logic [4:0] rd_o);
        bus.instr_id = id; bus.rs1 = a; bus.rs2 = b; bus.rd_addr_in = rd; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'h1234_5678; bus.rd_addr_in = 5'd0;
        lat = 1; stall_ok = 1'b1;
        while (!bus.result_valid && lat < LIMIT) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        res = bus.result; rd_o = bus.rd_addr_out;
        @(posedge clk); #1;
        pulse_ok = (bus.result_valid === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.instr_id = INSTR_ADD; bus.rs1 = '0; bus.rs2 = '0;
        bus.rd_addr_in = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.stall, bus.result_valid} !== 3'b000 || bus.result !== 32'h0 ||
            bus.rd_addr_out !== 5'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b stall=%b valid=%b result=%h rd=%h, want all 0",
                     bus.busy, bus.stall, bus.result_valid, bus.result, bus.rd_addr_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        logic [31:0] r; int lat; bit sok, pok; logic [4:0] rd;
        run_op(INSTR_MUL, 32'd7, 32'hFFFF_FFFD, 5'd17, r, lat, sok, pok, rd);
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL mul_latency: got %0d want 33", lat); end
        checks++;
        if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result: got %h want ffffffeb", r); end
        checks++;
        if (rd !== 5'd17) begin failures++; $display("FAIL mul_rd: got %0d want 17", rd); end
        checks++;
        if (!sok) begin failures++; $display("FAIL mul_stall: got stall profile bad, want 1 in BUSY, 0 in DONE"); end
        checks++;
        if (!pok) begin failures++; $display("FAIL mul_pulse: got valid/busy still high, want 0 after DONE"); end
    endtask

    task automatic test_mulh_variants;
        logic [31:0] r; int lat; bit sok, pok; logic [4:0] rd;
        run_op(INSTR_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu: got %h want fffffffe", r); end
        run_op(INSTR_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL mulh: got %h want 00000000", r); end
        run_op(INSTR_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu: got %h want ffffffff", r); end
    endtask

    task automatic test_div;
        logic [31:0] r; int lat; bit sok, pok; logic [4:0] rd;
        run_op(INSTR_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div: got %h want fffffffd", r); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL div_latency: got %0d want 33", lat); end
        run_op(INSTR_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem: got %h want ffffffff", r); end
        run_op(INSTR_DIVU, 32'd100, 32'd7, 5'd6, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'd14) begin failures++; $display("FAIL divu: got %0d want 14", r); end
        run_op(INSTR_REMU, 32'd100, 32'd7, 5'd7, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'd2) begin failures++; $display("FAIL remu: got %0d want 2", r); end
    endtask

    task automatic test_special;
        logic [31:0] r; int lat; bit sok, pok; logic [4:0] rd;
        run_op(INSTR_DIV, 32'd5, 32'd0, 5'd8, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1) begin
            failures++; $display("FAIL div_by_zero: got %h lat %0d want ffffffff lat 1", r, lat);
        end
        run_op(INSTR_REM, 32'd5, 32'd0, 5'd9, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'd5 || lat !== 1) begin
            failures++; $display("FAIL rem_by_zero: got %h lat %0d want 00000005 lat 1", r, lat);
        end
        run_op(INSTR_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 1) begin
            failures++; $display("FAIL div_overflow: got %h lat %0d want 80000000 lat 1", r, lat);
        end
        run_op(INSTR_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'h0 || lat !== 1) begin
            failures++; $display("FAIL rem_overflow: got %h lat %0d want 00000000 lat 1", r, lat);
        end
    endtask

    task automatic test_flush;
        logic [31:0] r; int lat; bit sok, pok; logic [4:0] rd; bit seen;
        bus.instr_id = INSTR_DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            failures++; $display("FAIL flush_idle: got busy=%b stall=%b want 0 0", bus.busy, bus.stall);
        end
        seen = 1'b0;
        repeat (40) begin if (bus.result_valid) seen = 1'b1; @(posedge clk); #1; end
        checks++;
        if (seen) begin failures++; $display("FAIL flush_no_valid: got a result_valid pulse, want none"); end
        run_op(INSTR_MUL, 32'd3, 32'd4, 5'd12, r, lat, sok, pok, rd);
        checks++;
        if (r !== 32'd12) begin failures++; $display("FAIL mul_after_flush: got %0d want 12", r); end
    endtask

    task automatic test_reset_mid_busy;
        bus.instr_id = INSTR_MUL; bus.rs1 = 32'd9; bus.rs2 = 32'd9; bus.rd_addr_in = 5'd20;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.stall, bus.result_valid} !== 3'b000 || bus.result !== 32'h0 ||
            bus.rd_addr_out !== 5'h0) begin
            failures++;
            $display("FAIL reset_mid_busy: busy=%b stall=%b valid=%b result=%h rd=%h, want all 0",
                     bus.busy, bus.stall, bus.result_valid, bus.result, bus.rd_addr_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_non_m;
        bus.instr_id = INSTR_ADD; bus.rs1 = 32'd1; bus.rs2 = 32'd2; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL non_m_comb: got stall=%b busy=%b want 0 0", bus.stall, bus.busy);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++; $display("FAIL non_m_state: got busy=%b valid=%b want 0 0", bus.busy, bus.result_valid);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh_variants();
        test_div();
        test_special();
        test_flush();
        test_reset_mid_busy();
        test_non_m();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
